// File: rtl/leaderboard_sound_player.sv
// leaderboard_sound_player: plays rank-specific beep patterns on a piezo for leaderboard rank-change strobes.
// Optional LB_SOUND_PREEMPT_EN: a higher-priority rise aborts the pattern currently playing.
module leaderboard_sound_player #(
  parameter int BEEP_CYC = 10_000_000,
  parameter int GAP_CYC  = 5_000_000,
  parameter int HALF1    = 25_000,
  parameter int HALF2    = 33_333,
  parameter int HALF3    = 50_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       signal_sound_1,
  input  logic       signal_sound_2,
  input  logic       signal_sound_3,
  input  logic       mute,
  output logic       buzzer,
  output logic       playing,
  output logic [1:0] rank_playing
);
  localparam int DMAX = (BEEP_CYC > GAP_CYC) ? BEEP_CYC : GAP_CYC;
  localparam int HM12 = (HALF1 > HALF2) ? HALF1 : HALF2;
  localparam int HMAX = (HM12 > HALF3) ? HM12 : HALF3;
  localparam int DW = $clog2(DMAX + 1);
  localparam int TW = $clog2(HMAX + 1);
  localparam logic [DW-1:0] BEEP_END = DW'(BEEP_CYC - 1);
  localparam logic [DW-1:0] GAP_END  = DW'(GAP_CYC - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_BEEP, ST_GAP} state_t;

  state_t        r_state, w_nx_state;
  logic [3:1]    r_s_q, w_rise;
  logic [1:0]    r_rank, r_left, r_pend, w_nx_rank, w_nx_left, w_nx_pend;
  logic [1:0]    w_hi, w_lo, w_pm;
  logic [DW-1:0] r_dur, w_nx_dur;
  logic [TW-1:0] r_tone, w_half_end;
  logic          r_sq, r_mute, w_enter;

  // Smaller nonzero rank wins; 0 means empty.
  function automatic logic [1:0] f_min(input logic [1:0] a, input logic [1:0] b);
    return (a == 2'd0) ? b : (b != 2'd0 && b < a) ? b : a;
  endfunction

  assign w_rise = {signal_sound_3, signal_sound_2, signal_sound_1} & ~r_s_q;
  assign w_hi = w_rise[1] ? 2'd1 : w_rise[2] ? 2'd2 : w_rise[3] ? 2'd3 : 2'd0;
  assign w_lo = w_rise[1] ? (w_rise[2] ? 2'd2 : w_rise[3] ? 2'd3 : 2'd0)
                          : (w_rise[2] & w_rise[3]) ? 2'd3 : 2'd0;
  assign w_pm = f_min(r_pend, w_hi);
  assign w_half_end = (r_rank == 2'd1) ? TW'(HALF1 - 1) :
                      (r_rank == 2'd2) ? TW'(HALF2 - 1) : TW'(HALF3 - 1);

  always_comb begin
    w_nx_state = r_state;
    w_nx_rank  = r_rank;
    w_nx_left  = r_left;
    w_nx_pend  = r_pend;
    w_nx_dur   = r_dur + 1'b1;
    w_enter    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_nx_dur = '0;
        if (w_hi != 2'd0) begin
          w_nx_state = ST_BEEP;
          w_nx_rank  = w_hi;
          w_nx_left  = 2'd0 - w_hi;
          w_nx_pend  = w_lo;
          w_enter    = 1'b1;
        end
      end
      ST_BEEP: begin
        w_nx_pend = w_pm;
        if (r_dur == BEEP_END) begin
          w_nx_state = ST_GAP;
          w_nx_dur   = '0;
        end
      end
      default: begin
        w_nx_pend = w_pm;
        if (r_dur == GAP_END) begin
          w_nx_dur = '0;
          if (r_left != 2'd1) begin
            w_nx_state = ST_BEEP;
            w_nx_left  = r_left - 2'd1;
            w_enter    = 1'b1;
          end else if (w_pm != 2'd0) begin
            w_nx_state = ST_BEEP;
            w_nx_rank  = w_pm;
            w_nx_left  = 2'd0 - w_pm;
            w_nx_pend  = 2'd0;
            w_enter    = 1'b1;
          end else begin
            w_nx_state = ST_IDLE;
            w_nx_rank  = 2'd0;
            w_nx_left  = 2'd0;
            w_nx_pend  = 2'd0;
          end
        end
      end
    endcase
`ifdef LB_SOUND_PREEMPT_EN
    if (r_state != ST_IDLE && w_hi != 2'd0 && w_hi < r_rank) begin
      w_nx_state = ST_BEEP;
      w_nx_rank  = w_hi;
      w_nx_left  = 2'd0 - w_hi;
      w_nx_pend  = f_min(r_pend, w_lo);
      w_nx_dur   = '0;
      w_enter    = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_s_q   <= 3'b111;
      r_rank  <= 2'd0;
      r_left  <= 2'd0;
      r_pend  <= 2'd0;
      r_dur   <= '0;
      r_tone  <= '0;
      r_sq    <= 1'b0;
      r_mute  <= 1'b0;
    end else begin
      r_state <= w_nx_state;
      r_s_q   <= {signal_sound_3, signal_sound_2, signal_sound_1};
      r_rank  <= w_nx_rank;
      r_left  <= w_nx_left;
      r_pend  <= w_nx_pend;
      r_dur   <= w_nx_dur;
      r_mute  <= mute;
      if (w_enter || r_state != ST_BEEP) begin
        r_tone <= '0;
        r_sq   <= 1'b0;
      end else if (r_tone == w_half_end) begin
        r_tone <= '0;
        r_sq   <= ~r_sq;
      end else begin
        r_tone <= r_tone + 1'b1;
      end
    end
  end

  assign buzzer       = (r_state == ST_BEEP) & r_sq & ~r_mute;
  assign playing      = r_state != ST_IDLE;
  assign rank_playing = r_rank;
endmodule

// File: tb/tb_leaderboard_sound_player.sv
// tb_leaderboard_sound_player: directed scenarios with cycle-by-cycle expected buzzer/playing/rank values.
module tb_leaderboard_sound_player;
  logic       clk = 1'b0, rst_n = 1'b0, s1 = 1'b1, s2 = 1'b1, s3 = 1'b1, mute = 1'b0;
  logic       buzzer, playing;
  logic [1:0] rank_playing;
  int         n_pass = 0, n_chk = 0;

  always #5 clk = ~clk;

  leaderboard_sound_player #(.BEEP_CYC(20), .GAP_CYC(10), .HALF1(2), .HALF2(3), .HALF3(4)) dut (
    .clk(clk), .rst_n(rst_n), .signal_sound_1(s1), .signal_sound_2(s2), .signal_sound_3(s3),
    .mute(mute), .buzzer(buzzer), .playing(playing), .rank_playing(rank_playing)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected tone at offset p within a 30-cycle beep+gap slot.
  function automatic logic exp_buzz(input int p, input int half);
    return (p < 20) ? (((p / half) % 2) == 1) : 1'b0;
  endfunction

  task automatic test_reset;
    step(3);
    if ({playing, rank_playing, buzzer} !== 4'b0) begin
      $display("FAIL reset_hold got p=%b r=%0d b=%b want 0/0/0", playing, rank_playing, buzzer);
    end else n_pass++;
    n_chk++;
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step(1);
      if ({playing, rank_playing, buzzer} !== 4'b0) begin
        $display("FAIL reset_release c=%0d got p=%b r=%0d b=%b want 0/0/0", c, playing, rank_playing, buzzer);
      end else n_pass++;
      n_chk++;
    end
    s1 = 1'b0; s2 = 1'b0; s3 = 1'b0;
    step(2);
  endtask

  task automatic test_rank3;
    logic ep, eb;
    logic [1:0] er;
    s3 = 1'b1;
    step(1);
    for (int c = 0; c < 33; c++) begin
      ep = c < 30;
      er = (c < 30) ? 2'd3 : 2'd0;
      eb = (c < 30) ? exp_buzz(c, 4) : 1'b0;
      if ({playing, rank_playing, buzzer} !== {ep, er, eb}) begin
        $display("FAIL rank3 c=%0d got p=%b r=%0d b=%b want p=%b r=%0d b=%b", c, playing, rank_playing, buzzer, ep, er, eb);
      end else n_pass++;
      n_chk++;
      if (c == 2) s3 = 1'b0;
      step(1);
    end
  endtask

  task automatic test_rank1;
    logic ep, eb;
    logic [1:0] er;
    s1 = 1'b1;
    step(1);
    for (int c = 0; c < 93; c++) begin
      ep = c < 90;
      er = (c < 90) ? 2'd1 : 2'd0;
      eb = (c < 90) ? exp_buzz(c % 30, 2) : 1'b0;
      if ({playing, rank_playing, buzzer} !== {ep, er, eb}) begin
        $display("FAIL rank1 c=%0d got p=%b r=%0d b=%b want p=%b r=%0d b=%b", c, playing, rank_playing, buzzer, ep, er, eb);
      end else n_pass++;
      n_chk++;
      if (c == 2) s1 = 1'b0;
      step(1);
    end
  endtask

  task automatic test_simultaneous;
    logic ep, eb;
    logic [1:0] er;
    s2 = 1'b1; s3 = 1'b1;
    step(1);
    for (int c = 0; c < 93; c++) begin
      ep = c < 90;
      er = (c < 60) ? 2'd2 : (c < 90) ? 2'd3 : 2'd0;
      eb = (c < 60) ? exp_buzz(c % 30, 3) : (c < 90) ? exp_buzz(c - 60, 4) : 1'b0;
      if ({playing, rank_playing, buzzer} !== {ep, er, eb}) begin
        $display("FAIL simultaneous c=%0d got p=%b r=%0d b=%b want p=%b r=%0d b=%b", c, playing, rank_playing, buzzer, ep, er, eb);
      end else n_pass++;
      n_chk++;
      if (c == 2) begin s2 = 1'b0; s3 = 1'b0; end
      step(1);
    end
  endtask

  task automatic test_higher_rank;
    logic ep, eb;
    logic [1:0] er;
    int t1;
`ifdef LB_SOUND_PREEMPT_EN
    t1 = 5;
`else
    t1 = 30;
`endif
    s3 = 1'b1;
    step(1);
    for (int c = 0; c < t1 + 93; c++) begin
      ep = c < t1 + 90;
      er = (c < t1) ? 2'd3 : (c < t1 + 90) ? 2'd1 : 2'd0;
      eb = (c < t1) ? exp_buzz(c, 4) : (c < t1 + 90) ? exp_buzz((c - t1) % 30, 2) : 1'b0;
      if ({playing, rank_playing, buzzer} !== {ep, er, eb}) begin
        $display("FAIL higher_rank c=%0d got p=%b r=%0d b=%b want p=%b r=%0d b=%b", c, playing, rank_playing, buzzer, ep, er, eb);
      end else n_pass++;
      n_chk++;
      if (c == 2) s3 = 1'b0;
      if (c == 4) s1 = 1'b1;
      if (c == 7) s1 = 1'b0;
      step(1);
    end
  endtask

  task automatic test_requeue_same;
    logic ep, eb;
    logic [1:0] er;
    s3 = 1'b1;
    step(1);
    for (int c = 0; c < 63; c++) begin
      ep = c < 60;
      er = (c < 60) ? 2'd3 : 2'd0;
      eb = (c < 60) ? exp_buzz(c % 30, 4) : 1'b0;
      if ({playing, rank_playing, buzzer} !== {ep, er, eb}) begin
        $display("FAIL requeue c=%0d got p=%b r=%0d b=%b want p=%b r=%0d b=%b", c, playing, rank_playing, buzzer, ep, er, eb);
      end else n_pass++;
      n_chk++;
      if (c == 2) s3 = 1'b0;
      if (c == 24) s3 = 1'b1;
      if (c == 27) s3 = 1'b0;
      step(1);
    end
  endtask

  task automatic test_mute_reset;
    logic eb;
    s2 = 1'b1;
    step(1);
    for (int c = 0; c < 12; c++) begin
      eb = (c >= 4 && c <= 9) ? 1'b0 : exp_buzz(c, 3);
      if ({playing, rank_playing, buzzer} !== {1'b1, 2'd2, eb}) begin
        $display("FAIL mute c=%0d got p=%b r=%0d b=%b want p=1 r=2 b=%b", c, playing, rank_playing, buzzer, eb);
      end else n_pass++;
      n_chk++;
      if (c == 3) mute = 1'b1;
      if (c == 9) mute = 1'b0;
      step(1);
    end
    rst_n = 1'b0;
    #1;
    if ({playing, rank_playing, buzzer} !== 4'b0) begin
      $display("FAIL async_reset got p=%b r=%0d b=%b want 0/0/0", playing, rank_playing, buzzer);
    end else n_pass++;
    n_chk++;
    step(2);
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step(1);
      if ({playing, rank_playing, buzzer} !== 4'b0) begin
        $display("FAIL no_replay c=%0d got p=%b r=%0d b=%b want 0/0/0", c, playing, rank_playing, buzzer);
      end else n_pass++;
      n_chk++;
    end
    s2 = 1'b0;
    step(2);
  endtask

  initial begin
    test_reset();
    test_rank3();
    test_rank1();
    test_simultaneous();
    test_higher_rank();
    test_requeue_same();
    test_mute_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/leaderboard_sound_player.md
# leaderboard_sound_player

Downstream consumer of the leaderboard's rank-change strobes (`signal_sound_1/2/3`). It detects rising edges on each strobe and plays a rank-specific beep pattern as a square wave on the piezo buzzer pin: rank 1 plays three beeps at the highest pitch, rank 3 plays one beep at the lowest pitch. Requests that arrive while a pattern is playing are queued in a single priority-ordered pending slot, so a new record is never silently dropped behind an older one.

## Interface
- `BEEP_CYC`, 10_000_000: length of one beep, in clocks.
- `GAP_CYC`, 5_000_000: silence after each beep, in clocks.
- `HALF1`, 25_000: tone half-period for rank 1, in clocks.
- `HALF2`, 33_333: tone half-period for rank 2, in clocks.
- `HALF3`, 50_000: tone half-period for rank 3, in clocks.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  reset. Asynchronous, active-low.
- `signal_sound_1`  in  1  rank-1 change strobe from the leaderboard; level, same clock domain.
- `signal_sound_2`  in  1  rank-2 change strobe.
- `signal_sound_3`  in  1  rank-3 change strobe.
- `mute`  in  1  gates the buzzer to 0; sequencing is unaffected.
- `buzzer`  out  1  square-wave drive for the piezo.
- `playing`  out  1  high while a pattern is in progress (BEEP or GAP).
- `rank_playing`  out  2  rank currently playing (1–3); 0 when idle.

## Operation
- **Edge detect:** a register `s_q[3:1]` holds each input from the previous cycle. `rise_k = signal_sound_k & ~s_q[k]`. The `s_q` registers reset to 1, so an input that is held high through reset never triggers.
- **Priority:** rank 1 > rank 2 > rank 3. If several strobes rise in the same cycle, the highest-priority rank is serviced and the next highest is queued. Any remaining lower rank is dropped.
- **FSM states:**
  - IDLE
    - On any rise: go to BEEP with `rank = highest` and `beep_left = 4 - rank`.
  - BEEP
    - Lasts exactly `BEEP_CYC` cycles, then go to GAP.
  - GAP
    - Lasts exactly `GAP_CYC` cycles.
    - Then decrement `beep_left`. If it is nonzero, go to BEEP.
    - Else, if `pend != 0`, go to BEEP with `rank = pend` and clear `pend`, in the same cycle.
    - Else, go to IDLE.
- **Pending slot:** `pend[1:0]`, where 0 means empty. A rise during BEEP or GAP sets `pend = (pend == 0) ? k : min(pend, k)`. A rise of the rank already playing is also queued.
- **Tone generation:**
  - The tone counter clears to 0 on every BEEP entry, and `buzzer` enters BEEP at 0.
  - When the counter reaches `HALF_rank - 1`, `buzzer` toggles and the counter clears.
  - `buzzer = 0` in IDLE and GAP, and whenever `mute` = 1.
- **Counter widths:** the duration counter is wide enough for `max(BEEP_CYC, GAP_CYC)` and the tone counter for `max(HALFk)`. Neither counter wraps; both are cleared on every state entry.
- **Reset values (all outputs and state):** `buzzer` 0, `playing` 0, `rank_playing` 0, FSM IDLE, `pend` 0, counters 0.
- **Reset mid-pattern:** all of the above take effect immediately and asynchronously. Playback is not resumed after reset.

## Timing
- **Start latency:** an input that rises before clock edge t is detected at edge t. `playing` = 1 and `rank_playing` = k from edge t onward, i.e. 1 cycle after the input change.
- **First tone edge:** `buzzer` first goes high `HALF_rank` cycles after BEEP entry. The tone period is `2*HALF_rank` cycles.
- **Pattern length:** a rank-r pattern keeps `playing` high for exactly `(4 - r)*(BEEP_CYC + GAP_CYC)` cycles.
- **Queued patterns:** a queued pattern starts on the cycle after the final GAP cycle. `playing` does not drop in between.
- **Mute timing:** the `mute` gate is registered, so `buzzer` goes to 0 one cycle after `mute` rises.

## Configuration
- **`LB_SOUND_PREEMPT_EN` defined:** a rise of rank k while a rank greater than k is playing aborts the current pattern on that edge.
  - The FSM restarts BEEP with rank k. Counters and `buzzer` clear, and `beep_left = 4 - k`.
  - The aborted rank is discarded, not queued.
  - A rise of an equal or lower-priority rank is still queued in `pend`.
- **`LB_SOUND_PREEMPT_EN` not defined:** no preemption. Every rise during playback goes through `pend` as described in Operation.

## Test plan
All scenarios use `BEEP_CYC` = 20, `GAP_CYC` = 10, `HALF1` = 2, `HALF2` = 3, `HALF3` = 4.
- **Reset:** hold `rst_n` = 0 with all strobes high, then release -> `buzzer`, `playing` and `rank_playing` stay 0 indefinitely.
- **Single rank-3 request:** one rise on `signal_sound_3` -> `playing` high for 30 cycles and `rank_playing` = 3. `buzzer` has period 8 (first high at cycle 4 of BEEP) for 20 cycles, then is 0 for 10 cycles.
- **Single rank-1 request:** one rise on `signal_sound_1` -> three 20-cycle bursts of period 4, each followed by a 10-cycle gap. `playing` is high for 90 cycles.
- **Simultaneous requests:** ranks 2 and 3 rise on the same edge -> rank 2 plays for 60 cycles, then rank 3 for 30. `playing` stays high continuously for 90 cycles.
- **Higher rank during playback:** rank 3 is playing and rank 1 rises at BEEP cycle 5.
  - Without the macro: rank 3 completes at cycle 30, then `rank_playing` = 1 for 90 cycles.
  - With `LB_SOUND_PREEMPT_EN`: `rank_playing` = 1 from the next cycle, and the pattern lasts 90 cycles.
- **Mute and reset mid-beep:** asserting `mute` mid-BEEP -> `buzzer` is 0 one cycle later while `playing` stays 1. Asserting `rst_n` = 0 mid-BEEP -> all outputs are 0 immediately, and a strobe still held high after release does not replay.
